// File: rtl/hptdc_jtag_pkg.sv
// rtl/hptdc_jtag_pkg.sv - HPTDC JTAG instruction codes, register lengths and sequencer types
package hptdc_jtag_pkg;

    localparam logic [4:0] INSTR_EXTEST    = 5'h00;
    localparam logic [4:0] INSTR_IDCODE    = 5'h01;
    localparam logic [4:0] INSTR_SAMPLE    = 5'h02;
    localparam logic [4:0] INSTR_INTEST    = 5'h03;
    localparam logic [4:0] INSTR_BIST      = 5'h04;
    localparam logic [4:0] INSTR_SCAN      = 5'h05;
    localparam logic [4:0] INSTR_RSVD_06   = 5'h06;
    localparam logic [4:0] INSTR_CORETEST  = 5'h07;
    localparam logic [4:0] INSTR_SETUP     = 5'h08;
    localparam logic [4:0] INSTR_CONTROL   = 5'h09;
    localparam logic [4:0] INSTR_STATUS    = 5'h0A;
    localparam logic [4:0] INSTR_FULL_SCAN = 5'h0B;
    localparam logic [4:0] INSTR_BYPASS    = 5'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FREE,
        ST_STROBE,
        ST_XFER,
        ST_CAPTURE,
        ST_COMPARE,
        ST_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        RSP_OK         = 2'b00,
        RSP_VERIFY_ERR = 2'b01,
        RSP_START_TMO  = 2'b10,
        RSP_XFER_TMO   = 2'b11
    } rsp_status_e;

    // Index of the top valid bit; chains longer than the data path are clamped to it.
    function automatic int unsigned instr_len(input logic [4:0] instr, input int unsigned data_w);
        int unsigned raw;
        case (instr)
            INSTR_EXTEST:    raw = 83;
            INSTR_IDCODE:    raw = 32;
            INSTR_SAMPLE:    raw = 0;
            INSTR_INTEST:    raw = 0;
            INSTR_BIST:      raw = 10;
            INSTR_SCAN:      raw = 1829;
            INSTR_RSVD_06:   raw = 0;
            INSTR_CORETEST:  raw = 33;
            INSTR_SETUP:     raw = 647;
            INSTR_CONTROL:   raw = 40;
            INSTR_STATUS:    raw = 62;
            INSTR_FULL_SCAN: raw = 749;
            INSTR_BYPASS:    raw = 0;
            default:         raw = 0;
        endcase
        return (raw > data_w - 1) ? data_w - 1 : raw;
    endfunction

    function automatic logic in_reg(input logic [4:0] instr, input int unsigned data_w,
                                    input int unsigned idx);
        return idx <= instr_len(instr, data_w);
    endfunction

endpackage

// File: rtl/hptdc_jtag_len_mask.sv
// rtl/hptdc_jtag_len_mask.sv - combinational instruction to valid-bit mask of the selected register
module hptdc_jtag_len_mask
    import hptdc_jtag_pkg::*;
#(
    parameter int DATA_W  = 749,
    parameter int INSTR_W = 5
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  mask
);

    logic [4:0] code;

    assign code = 5'(instr);

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign mask[i] = in_reg(code, DATA_W, i);
    end

endmodule

// File: rtl/hptdc_jtag_sequencer.sv
// rtl/hptdc_jtag_sequencer.sv - single-request sequencer in front of the HPTDC JTAG master
module hptdc_jtag_sequencer
    import hptdc_jtag_pkg::*;
#(
    parameter int DATA_W    = 749,
    parameter int INSTR_W   = 5,
    parameter int START_TMO = 16,
    parameter int XFER_TMO  = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [INSTR_W-1:0] req_instr,
    input  logic               req_write,
    input  logic               req_verify,
    input  logic [DATA_W-1:0]  req_data,
    output logic               rsp_valid,
    output logic [1:0]         rsp_status,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               busy,
    output logic               send_data_to_hptdc,
    output logic               get_data_from_hptdc,
    output logic [DATA_W-1:0]  data_to_hptdc,
    output logic [INSTR_W-1:0] jtag_instruction,
    input  logic               jtag_bus_in_use,
    input  logic               data_received_from_hptdc,
    input  logic [DATA_W-1:0]  data_from_hptdc
);

    localparam int TMO_MAX = (XFER_TMO > START_TMO) ? XFER_TMO : START_TMO;
    localparam int CNT_W   = $clog2(TMO_MAX + 1);

    seq_state_e        state;
    seq_state_e        state_nxt;
    rsp_status_e       status_q;
    logic [CNT_W-1:0]  cnt;
    logic              read_phase;
    logic              verify_q;
    logic [DATA_W-1:0] mask;
    logic              accept;
    logic              start_tmo_hit;
    logic              xfer_tmo_hit;
    logic              mismatch;
    logic              unused_info;

    // Mask follows the latched instruction, so it is valid from accept through DONE.
    hptdc_jtag_len_mask #(
        .DATA_W  (DATA_W),
        .INSTR_W (INSTR_W)
    ) u_len_mask (
        .instr (jtag_instruction),
        .mask  (mask)
    );

    assign unused_info   = data_received_from_hptdc;
    assign accept        = req_valid && (state == ST_IDLE);
    assign start_tmo_hit = (state == ST_STROBE) && !jtag_bus_in_use
                           && (cnt == CNT_W'(START_TMO - 1));
    assign xfer_tmo_hit  = (state == ST_XFER) && jtag_bus_in_use
                           && (cnt == CNT_W'(XFER_TMO - 1));
    assign mismatch      = |((rsp_data ^ data_to_hptdc) & mask);
    assign rsp_status    = status_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = jtag_bus_in_use ? ST_WAIT_FREE : ST_STROBE;
                end
            end
            ST_WAIT_FREE: begin
                if (!jtag_bus_in_use) begin
                    state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (jtag_bus_in_use) begin
                    state_nxt = ST_XFER;
                end else if (start_tmo_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_XFER: begin
                if (!jtag_bus_in_use) begin
                    state_nxt = ST_CAPTURE;
                end else if (xfer_tmo_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                if (verify_q && !read_phase) begin
                    state_nxt = ST_STROBE;
                end else if (verify_q && read_phase) begin
                    state_nxt = ST_COMPARE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_COMPARE: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready           = 1'b0;
        busy                = 1'b1;
        rsp_valid           = 1'b0;
        send_data_to_hptdc  = 1'b0;
        get_data_from_hptdc = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_STROBE: begin
                send_data_to_hptdc  = !read_phase;
                get_data_from_hptdc = read_phase;
            end
            ST_DONE:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt              <= '0;
            read_phase       <= 1'b0;
            verify_q         <= 1'b0;
            status_q         <= RSP_OK;
            rsp_data         <= '0;
            data_to_hptdc    <= '0;
            jtag_instruction <= '0;
        end else begin
            // The counter only runs while waiting on the master in STROBE or XFER.
            if ((state_nxt != state) || !((state == ST_STROBE) || (state == ST_XFER))) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (accept) begin
                data_to_hptdc    <= req_data;
                jtag_instruction <= req_instr;
                verify_q         <= req_write && req_verify;
                read_phase       <= !req_write;
                status_q         <= RSP_OK;
                rsp_data         <= '0;
            end

            if (state == ST_CAPTURE) begin
                if (read_phase) begin
                    rsp_data <= data_from_hptdc & mask;
                end else if (verify_q) begin
                    read_phase <= 1'b1;
                end
            end

            if (start_tmo_hit) begin
                status_q <= RSP_START_TMO;
            end
            if (xfer_tmo_hit) begin
                status_q <= RSP_XFER_TMO;
            end
            if ((state == ST_COMPARE) && mismatch) begin
                status_q <= RSP_VERIFY_ERR;
            end
        end
    end

endmodule

// File: tb/tb_hptdc_jtag_sequencer.sv
// tb/tb_hptdc_jtag_sequencer.sv - self-checking bench for hptdc_jtag_sequencer
module tb_hptdc_jtag_sequencer;

    localparam int DATA_W  = 749;
    localparam int INSTR_W = 5;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [INSTR_W-1:0] req_instr = '0;
    logic               req_write = 1'b0;
    logic               req_verify = 1'b0;
    logic [DATA_W-1:0]  req_data = '0;
    logic               rsp_valid;
    logic [1:0]         rsp_status;
    logic [DATA_W-1:0]  rsp_data;
    logic               busy;
    logic               send_data_to_hptdc;
    logic               get_data_from_hptdc;
    logic [DATA_W-1:0]  data_to_hptdc;
    logic [INSTR_W-1:0] jtag_instruction;
    logic               jtag_bus_in_use;
    logic               data_received_from_hptdc;
    logic [DATA_W-1:0]  data_from_hptdc = '0;

    logic bus_m = 1'b0;
    logic force_busy = 1'b0;
    assign jtag_bus_in_use = bus_m | force_busy;
    assign data_received_from_hptdc = 1'b0;

    hptdc_jtag_sequencer dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_instr                (req_instr),
        .req_write                (req_write),
        .req_verify               (req_verify),
        .req_data                 (req_data),
        .rsp_valid                (rsp_valid),
        .rsp_status               (rsp_status),
        .rsp_data                 (rsp_data),
        .busy                     (busy),
        .send_data_to_hptdc       (send_data_to_hptdc),
        .get_data_from_hptdc      (get_data_from_hptdc),
        .data_to_hptdc            (data_to_hptdc),
        .jtag_instruction         (jtag_instruction),
        .jtag_bus_in_use          (jtag_bus_in_use),
        .data_received_from_hptdc (data_received_from_hptdc),
        .data_from_hptdc          (data_from_hptdc)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int len_tab [0:15] = '{83, 32, 0, 0, 10, 1829, 0, 33, 647, 40, 62, 749, 0, 0, 0, 0};
    logic [4:0] ilist [0:10] = '{5'h00, 5'h01, 5'h04, 5'h05, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0F, 5'h02};

    // Master model controls (written by the main sequence only)
    logic              m_enable = 1'b0;
    int                m_delay = 2;
    int                m_hold = 10;
    logic              m_echo = 1'b0;
    logic [DATA_W-1:0] m_flip = '0;
    logic [DATA_W-1:0] m_read_data = '0;
    // Master model observations (written by the master only)
    logic [DATA_W-1:0] m_written = '0;
    int                m_wr_count = 0;
    int                m_rd_count = 0;

    // Transaction observations
    logic              obs_done, obs_both, obs_stable, obs_after_valid, obs_after_ready;
    logic [1:0]        obs_status;
    logic [DATA_W-1:0] obs_data;
    int                obs_send, obs_get, obs_seq, obs_pre, obs_xfer;
    logic              stick_on_strobe = 1'b0;
    int                release_at = -1;
    logic              hammer = 1'b0;

    function automatic logic [DATA_W-1:0] rand_vec();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] ref_mask(input logic [4:0] instr);
        logic [DATA_W-1:0] m;
        int len;
        len = (instr < 5'd16) ? len_tab[instr[3:0]] : 0;
        if (len > DATA_W - 1) len = DATA_W - 1;
        for (int i = 0; i < DATA_W; i++) m[i] = (i <= len);
        return m;
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural JTAG master: busy rises m_delay cycles after a strobe, falls after m_hold.
    initial begin : master
        logic is_get;
        forever begin
            @(negedge clk);
            if (rstn && m_enable && !bus_m && (send_data_to_hptdc || get_data_from_hptdc)) begin
                is_get = get_data_from_hptdc;
                if (is_get) begin
                    data_from_hptdc = m_echo ? (m_written ^ m_flip) : m_read_data;
                    m_rd_count++;
                end else begin
                    m_written = data_to_hptdc;
                    m_wr_count++;
                end
                repeat (m_delay - 1) @(negedge clk);
                bus_m = 1'b1;
                for (int h = 0; h < m_hold; h++) begin
                    @(negedge clk);
                    if (!rstn) break;
                end
                bus_m = 1'b0;
            end
        end
    end

    task automatic run_txn(input logic [4:0] instr, input logic wr, input logic vf,
                           input logic [DATA_W-1:0] d, input int budget);
        logic ps, pg, seen;
        obs_done = 0; obs_both = 0; obs_stable = 1; obs_send = 0; obs_get = 0;
        obs_seq = 0; obs_pre = 0; obs_xfer = 0; obs_status = 'x; obs_data = 'x;
        ps = 0; pg = 0; seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_instr = instr; req_write = wr; req_verify = vf; req_data = d;
        @(posedge clk);
        #1;
        req_valid  = hammer;
        req_instr  = 5'($urandom);
        req_write  = 1'($urandom);
        req_verify = 1'($urandom);
        req_data   = rand_vec();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (send_data_to_hptdc) obs_send++;
            if (get_data_from_hptdc) obs_get++;
            if (send_data_to_hptdc && !ps) obs_seq = obs_seq * 4 + 1;
            if (get_data_from_hptdc && !pg) obs_seq = obs_seq * 4 + 2;
            if (send_data_to_hptdc && get_data_from_hptdc) obs_both = 1;
            if (jtag_instruction !== instr || data_to_hptdc !== d) obs_stable = 0;
            if (send_data_to_hptdc || get_data_from_hptdc) seen = 1;
            if (!seen && busy) obs_pre++;
            if (seen && !send_data_to_hptdc && !get_data_from_hptdc && !rsp_valid) obs_xfer++;
            ps = send_data_to_hptdc; pg = get_data_from_hptdc;
            if (stick_on_strobe && send_data_to_hptdc) force_busy = 1'b1;
            if (c == release_at) force_busy = 1'b0;
            if (rsp_valid) begin
                obs_done = 1; obs_status = rsp_status; obs_data = rsp_data;
                req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        obs_after_valid = rsp_valid;
        obs_after_ready = req_ready;
    endtask

    initial begin : main
        logic [DATA_W-1:0] d, rd, msk, exp_data;
        logic [4:0] instr;
        logic wr, vf;
        int wc, rc, n, exp_seq, bit_idx;
        logic [1:0] exp_status;

        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_send", send_data_to_hptdc, 0);
        check("rst_get", get_data_from_hptdc, 0);
        check("rst_status", rsp_status, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_data_to", data_to_hptdc, 0);
        check("rst_instr", jtag_instruction, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Plain write to the control register
        m_enable = 1; m_delay = 2; m_hold = 50; m_echo = 0;
        d = '0; d[39:0] = 40'h12_3456_789A;
        wc = m_wr_count;
        run_txn(5'h09, 1, 0, d, 300);
        check("wr_done", obs_done, 1);
        check("wr_send_cycles", obs_send, 2);
        check("wr_get_cycles", obs_get, 0);
        check("wr_status", obs_status, 2'b00);
        check("wr_rsp_data", obs_data, 0);
        check("wr_master_data", m_written, d);
        check("wr_master_count", m_wr_count - wc, 1);
        check("wr_single_pulse", obs_after_valid, 0);
        check("wr_ready_after", obs_after_ready, 1);
        check("wr_stable", obs_stable, 1);

        // ID read with garbage above the register length
        rd = rand_vec(); rd[31:0] = 32'h8470DACE; m_read_data = rd;
        run_txn(5'h01, 0, 0, rand_vec(), 300);
        check("id_done", obs_done, 1);
        check("id_seq", obs_seq, 2);
        check("id_status", obs_status, 2'b00);
        check("id_low_bits", obs_data[31:0], 32'h8470DACE);
        check("id_data", obs_data, rd & ref_mask(5'h01));
        check("id_upper_zero", obs_data >> 33, 0);

        // Verified setup writes: flip inside, none, flip beyond the register length
        m_echo = 1; m_delay = 3; m_hold = 40;
        for (int k = 0; k < 3; k++) begin
            d = rand_vec(); m_flip = '0;
            if (k == 0) m_flip[100] = 1'b1;
            if (k == 2) m_flip[700] = 1'b1;
            wc = m_wr_count; rc = m_rd_count;
            run_txn(5'h08, 1, 1, d, 600);
            check("vfy_done", obs_done, 1);
            check("vfy_seq", obs_seq, 6);
            check("vfy_counts", {m_wr_count - wc, m_rd_count - rc}, {32'd1, 32'd1});
            check("vfy_status", obs_status, (k == 0) ? 2'b01 : 2'b00);
            check("vfy_data", obs_data, (d ^ m_flip) & ref_mask(5'h08));
        end

        // Verify flag on a read is ignored
        m_echo = 0; m_read_data = rand_vec();
        run_txn(5'h0A, 0, 1, rand_vec(), 300);
        check("rdvfy_seq", obs_seq, 2);
        check("rdvfy_status", obs_status, 2'b00);
        check("rdvfy_data", obs_data, m_read_data & ref_mask(5'h0A));

        // Clamped full-width register and BYPASS
        m_read_data = rand_vec();
        run_txn(5'h05, 0, 0, rand_vec(), 300);
        check("scan_data", obs_data, m_read_data);
        run_txn(5'h0F, 0, 0, rand_vec(), 300);
        check("bypass_data", obs_data, {{(DATA_W-1){1'b0}}, m_read_data[0]});

        // Randomized requests against the reference model
        for (int k = 0; k < 8; k++) begin
            instr = ilist[$urandom_range(0, 10)];
            wr = 1'($urandom); vf = 1'($urandom);
            d = rand_vec(); rd = rand_vec();
            m_delay = $urandom_range(1, 4); m_hold = $urandom_range(1, 60);
            m_echo = wr && vf; m_read_data = rd; m_flip = '0;
            if ($urandom_range(0, 1) == 1) begin
                bit_idx = $urandom_range(0, DATA_W - 1);
                m_flip[bit_idx] = 1'b1;
            end
            hammer = 1'($urandom);
            wc = m_wr_count; rc = m_rd_count;
            run_txn(instr, wr, vf, d, 800);
            hammer = 0;
            msk = ref_mask(instr);
            exp_seq = !wr ? 2 : (vf ? 6 : 1);
            exp_data = !wr ? (rd & msk) : (vf ? ((d ^ m_flip) & msk) : '0);
            exp_status = (wr && vf && ((m_flip & msk) != '0)) ? 2'b01 : 2'b00;
            check("rnd_done", obs_done, 1);
            check("rnd_seq", obs_seq, exp_seq);
            check("rnd_status", obs_status, exp_status);
            check("rnd_data", obs_data, exp_data);
            check("rnd_no_both", obs_both, 0);
            check("rnd_stable", obs_stable, 1);
            check("rnd_counts", {m_wr_count - wc, m_rd_count - rc},
                  {32'(wr), 32'(!wr || vf)});
        end

        // Master never answers the strobe
        m_enable = 0;
        run_txn(5'h09, 1, 0, rand_vec(), 100);
        check("stmo_done", obs_done, 1);
        check("stmo_send_cycles", obs_send, 16);
        check("stmo_status", obs_status, 2'b10);
        check("stmo_ready_after", obs_after_ready, 1);

        // Busy at accept, then stuck high after the strobe
        force_busy = 1; stick_on_strobe = 1; release_at = 30;
        run_txn(5'h04, 1, 0, rand_vec(), 5000);
        stick_on_strobe = 0;
        check("xtmo_done", obs_done, 1);
        check("xtmo_wait_free", obs_pre, 31);
        check("xtmo_send_cycles", obs_send, 1);
        check("xtmo_xfer_cycles", obs_xfer, 4096);
        check("xtmo_status", obs_status, 2'b11);

        // Master still busy: the next request waits, then completes
        m_enable = 1; m_delay = 2; m_hold = 20; release_at = 10;
        run_txn(5'h09, 1, 0, rand_vec(), 300);
        release_at = -1;
        check("after_tmo_wait", obs_pre, 11);
        check("after_tmo_status", obs_status, 2'b00);

        // Reset in the middle of a transfer
        m_hold = 200;
        @(negedge clk);
        req_valid = 1; req_instr = 5'h01; req_write = 0; req_verify = 0; req_data = rand_vec();
        @(posedge clk);
        #1 req_valid = 0;
        repeat (20) @(negedge clk);
        check("rstx_busy_before", {busy, jtag_bus_in_use}, 2'b11);
        #2 rstn = 1'b0;
        #1;
        check("rstx_ready", req_ready, 1);
        check("rstx_outputs", {busy, rsp_valid, send_data_to_hptdc, get_data_from_hptdc, rsp_status}, 0);
        check("rstx_rsp_data", rsp_data, 0);
        check("rstx_data_to", data_to_hptdc, 0);
        check("rstx_instr", jtag_instruction, 0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        rstn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("rstx_no_rsp", n, 0);
        m_hold = 15; m_read_data = rand_vec();
        run_txn(5'h07, 0, 0, rand_vec(), 300);
        check("rstx_new_done", obs_done, 1);
        check("rstx_new_data", obs_data, m_read_data & ref_mask(5'h07));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
